// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state encoding, default geometry and address helpers for icache_dm
package icache_pkg;

  // Default cache geometry; icache_dm takes these as parameter defaults.
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINES  = 16;
  localparam int DEF_WORDS  = 4;

  // Address field widths for the default geometry.
  localparam int OFF   = $clog2(DEF_WORDS);
  localparam int IDX   = $clog2(DEF_LINES);
  localparam int TAG_W = DEF_ADDR_W - OFF - IDX - 2;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } cacheState_t;

  // Word-within-line select of a byte address.
  function automatic logic [OFF-1:0] pcWord(input logic [DEF_ADDR_W-1:0] pc);
    return OFF'(pc >> 2);
  endfunction

  // Line index of a byte address.
  function automatic logic [IDX-1:0] pcIndex(input logic [DEF_ADDR_W-1:0] pc);
    return IDX'(pc >> (OFF + 2));
  endfunction

  // Tag of a byte address.
  function automatic logic [TAG_W-1:0] pcTag(input logic [DEF_ADDR_W-1:0] pc);
    return TAG_W'(pc >> (OFF + IDX + 2));
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - instruction data and tag storage, async read, sync write
module icache_data_array #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAG_W = 26
) (
  input  logic                     clk,
  input  logic [$clog2(LINES)-1:0] rdIndex,
  input  logic [$clog2(WORDS)-1:0] rdWord,
  output logic [31:0]              rdData,
  output logic [TAG_W-1:0]         rdTag,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] wrIndex,
  input  logic [$clog2(WORDS)-1:0] wrWord,
  input  logic [31:0]              wdata,
  input  logic                     tagWe,
  input  logic [TAG_W-1:0]         wrTag
);

  // Storage is never reset; the valid bits in the parent make stale contents harmless.
  logic [31:0]      dataMem [LINES][WORDS];
  logic [TAG_W-1:0] tagMem  [LINES];

  assign rdData = dataMem[rdIndex][rdWord];
  assign rdTag  = tagMem[rdIndex];

  // Refill writes: one data word per transfer, tag on the final word.
  always_ff @(posedge clk) begin
    if (we) begin
      dataMem[wrIndex][wrWord] <= wdata;
    end
    if (tagWe) begin
      tagMem[wrIndex] <= wrTag;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with line refill FSM
module icache_dm
  import icache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINES  = DEF_LINES,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              req_i,
  input  logic              flush_i,
  output logic [31:0]       instr_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int wordBits = $clog2(WORDS);
  localparam int idxBits  = $clog2(LINES);
  localparam int tagBits  = ADDR_W - wordBits - idxBits - 2;
  localparam logic [wordBits-1:0] lastWord = wordBits'(WORDS - 1);

  cacheState_t state, stateNext;

  logic [wordBits-1:0] pcWordSel;
  logic [idxBits-1:0]  pcIdx;
  logic [tagBits-1:0]  pcTagVal;
  logic [tagBits-1:0]  lineTag;
  logic [tagBits-1:0]  baseTag;
  logic [idxBits-1:0]  baseIndex;
  logic [wordBits-1:0] cnt;
  logic [LINES-1:0]    valid;
  logic                hit;
  logic                missStart;
  logic                xfer;
  logic                lastXfer;

  // Byte-offset bits fall off in the shifts; the fetch stage only issues aligned PCs.
  assign pcWordSel = wordBits'(pc_i >> 2);
  assign pcIdx     = idxBits'(pc_i >> (wordBits + 2));
  assign pcTagVal  = tagBits'(pc_i >> (wordBits + idxBits + 2));

  assign hit      = valid[pcIdx] && (lineTag == pcTagVal);
  assign xfer     = mem_req_o && mem_ack_i;
  assign lastXfer = xfer && (cnt == lastWord);
  assign stall_o  = req_i && ((state != IDLE) || !hit);

  // Refill writes are steered by the latched base so PC changes mid-refill are harmless.
  icache_data_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (tagBits)
  ) u_dataArray (
    .clk     (clk),
    .rdIndex (pcIdx),
    .rdWord  (pcWordSel),
    .rdData  (instr_o),
    .rdTag   (lineTag),
    .we      (xfer),
    .wrIndex (baseIndex),
    .wrWord  (cnt),
    .wdata   (mem_rdata_i),
    .tagWe   (lastXfer),
    .wrTag   (baseTag)
  );

  // State register; reset abandons any refill in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and memory-request decode.
  always_comb begin
    stateNext  = state;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    missStart  = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && !hit) begin
          missStart = 1'b1;
          stateNext = REFILL;
        end
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {baseTag, baseIndex, cnt, 2'b00};
        if (lastXfer) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Latch the missing line's base and step the word counter on each transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      baseTag   <= '0;
      baseIndex <= '0;
    end else if (missStart) begin
      baseTag   <= pcTagVal;
      baseIndex <= pcIdx;
      cnt       <= '0;
    end else if (xfer) begin
      cnt <= lastXfer ? '0 : cnt + 1'b1;
    end
  end

  // Valid bits: flush clears all, a completing refill wins for its own line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else begin
      if (flush_i) begin
        valid <= '0;
      end
      if (lastXfer) begin
        valid[baseIndex] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - self-checking bench for icache_dm with a scoreboarded refill memory
module tb_icache_dm;

  localparam int FETCH_LIMIT = 200;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        req_i;
  logic        flush_i;
  logic [31:0] instr_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int compared   = 0;
  int mismatched = 0;
  int waitStates = 0;
  int waitCnt    = 0;

  logic [31:0] addrQ[$];

  icache_dm dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .req_i       (req_i),
    .flush_i     (flush_i),
    .instr_o     (instr_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing memory contents: word at 0x10 is 0xA0, 0x14 is 0xA1, ...
  function automatic logic [31:0] memFn(input logic [31:0] a);
    return 32'h0000_009C + (a >> 2);
  endfunction

  // Queue the four word addresses a refill of this line must request, in order.
  task automatic pushLine(input logic [31:0] base);
    for (int w = 0; w < 4; w++) addrQ.push_back(base + 32'(w * 4));
  endtask

  // Memory responder: inserts waitStates idle cycles before each ack and scoreboards addresses.
  initial begin
    logic [31:0] exp;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_o === 1'b1) begin
        if (waitCnt < waitStates) begin
          mem_ack_i = 1'b0;
          waitCnt++;
          if (addrQ.size() != 0) begin
            compared++;
            if (mem_addr_o !== addrQ[0]) begin
              mismatched++;
              $display("FAIL wait_addr_hold: got %h expected %h", mem_addr_o, addrQ[0]);
            end
          end
        end else begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = memFn(mem_addr_o);
          waitCnt     = 0;
          compared++;
          if (addrQ.size() == 0) begin
            mismatched++;
            $display("FAIL refill_addr: got unexpected request %h expected none", mem_addr_o);
          end else begin
            exp = addrQ.pop_front();
            if (mem_addr_o !== exp) begin
              mismatched++;
              $display("FAIL refill_addr: got %h expected %h", mem_addr_o, exp);
            end
          end
        end
      end else begin
        mem_ack_i = 1'b0;
        waitCnt   = 0;
      end
    end
  end

  // Present a fetch and hold it until the stall drops; reports stall cycles and the instruction.
  task automatic runFetch(input logic [31:0] pc, output int stallCycles, output logic [31:0] instr);
    @(negedge clk);
    pc_i  = pc;
    req_i = 1'b1;
    #1;
    stallCycles = 0;
    while (stall_o !== 1'b0 && stallCycles < FETCH_LIMIT) begin
      stallCycles++;
      @(negedge clk);
      #1;
    end
    instr = instr_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if (mem_req_o !== 1'b0) begin mismatched++; $display("FAIL reset_mem_req: got %b expected 0", mem_req_o); end
    compared++;
    if (mem_addr_o !== 32'h0) begin mismatched++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_o); end
    compared++;
    if (stall_o !== 1'b0) begin mismatched++; $display("FAIL reset_stall_idle: got %b expected 0", stall_o); end
    pc_i  = 32'h10;
    req_i = 1'b1;
    #1;
    compared++;
    if (stall_o !== 1'b1) begin mismatched++; $display("FAIL reset_forced_miss: got %b expected 1", stall_o); end
    req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    int n;
    logic [31:0] got;
    waitStates = 0;
    pushLine(32'h10);
    runFetch(32'h10, n, got);
    compared++;
    if (n != 5) begin mismatched++; $display("FAIL cold_stall_cycles: got %0d expected 5", n); end
    compared++;
    if (got !== 32'hA0) begin mismatched++; $display("FAIL cold_instr: got %h expected %h", got, 32'hA0); end
    runFetch(32'h1C, n, got);
    compared++;
    if (n != 0) begin mismatched++; $display("FAIL cold_hit_stall: got %0d expected 0", n); end
    compared++;
    if (got !== 32'hA3) begin mismatched++; $display("FAIL cold_hit_instr: got %h expected %h", got, 32'hA3); end
  endtask

  task automatic test_wait_states();
    int n;
    logic [31:0] got;
    waitStates = 2;
    pushLine(32'h20);
    runFetch(32'h20, n, got);
    compared++;
    if (n != 13) begin mismatched++; $display("FAIL wait_stall_cycles: got %0d expected 13", n); end
    waitStates = 0;
    for (int w = 0; w < 4; w++) begin
      runFetch(32'h20 + 32'(w * 4), n, got);
      compared++;
      if (n != 0 || got !== memFn(32'h20 + 32'(w * 4))) begin
        mismatched++;
        $display("FAIL wait_line_word%0d: got stall %0d instr %h expected stall 0 instr %h",
                 w, n, got, memFn(32'h20 + 32'(w * 4)));
      end
    end
  endtask

  task automatic test_conflict();
    int n;
    logic [31:0] got;
    pushLine(32'h110);
    runFetch(32'h110, n, got);
    compared++;
    if (n != 5 || got !== memFn(32'h110)) begin
      mismatched++;
      $display("FAIL conflict_fill: got stall %0d instr %h expected stall 5 instr %h", n, got, memFn(32'h110));
    end
    pushLine(32'h10);
    runFetch(32'h14, n, got);
    compared++;
    if (n != 5 || got !== 32'hA1) begin
      mismatched++;
      $display("FAIL conflict_evicted: got stall %0d instr %h expected stall 5 instr %h", n, got, 32'hA1);
    end
  endtask

  task automatic test_flush();
    int n;
    logic [31:0] got;
    pushLine(32'h00);
    runFetch(32'h00, n, got);
    compared++;
    if (n != 5) begin mismatched++; $display("FAIL flush_fill0: got %0d expected 5", n); end
    runFetch(32'h18, n, got);
    compared++;
    if (n != 0 || got !== 32'hA2) begin mismatched++; $display("FAIL flush_line1_resident: got stall %0d instr %h expected stall 0 instr a2", n, got); end
    @(negedge clk);
    req_i   = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    pushLine(32'h00);
    runFetch(32'h04, n, got);
    compared++;
    if (n != 5 || got !== memFn(32'h04)) begin mismatched++; $display("FAIL flush_line0_miss: got stall %0d instr %h expected stall 5 instr %h", n, got, memFn(32'h04)); end
    pushLine(32'h10);
    runFetch(32'h10, n, got);
    compared++;
    if (n != 5 || got !== 32'hA0) begin mismatched++; $display("FAIL flush_line1_miss: got stall %0d instr %h expected stall 5 instr a0", n, got); end

    // Flush landing on the final ack of a line-3 refill.
    pushLine(32'h30);
    @(negedge clk);
    pc_i  = 32'h30;
    req_i = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    compared++;
    if (stall_o !== 1'b1) begin mismatched++; $display("FAIL flush_final_pending: got %b expected 1", stall_o); end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    compared++;
    if (stall_o !== 1'b0 || instr_o !== memFn(32'h30)) begin
      mismatched++;
      $display("FAIL flush_final_line_valid: got stall %b instr %h expected stall 0 instr %h", stall_o, instr_o, memFn(32'h30));
    end
    pushLine(32'h00);
    runFetch(32'h00, n, got);
    compared++;
    if (n != 5) begin mismatched++; $display("FAIL flush_final_other0: got %0d expected 5", n); end
    pushLine(32'h10);
    runFetch(32'h10, n, got);
    compared++;
    if (n != 5) begin mismatched++; $display("FAIL flush_final_other1: got %0d expected 5", n); end
  endtask

  task automatic test_pc_wobble();
    int n;
    logic [31:0] got;
    pushLine(32'h50);
    @(negedge clk);
    pc_i  = 32'h50;
    req_i = 1'b1;
    @(negedge clk);
    pc_i = 32'h134;
    #1;
    compared++;
    if (stall_o !== 1'b1) begin mismatched++; $display("FAIL wobble_stall_a: got %b expected 1", stall_o); end
    @(negedge clk);
    pc_i = 32'h18;
    #1;
    compared++;
    if (stall_o !== 1'b1) begin mismatched++; $display("FAIL wobble_stall_hitpc: got %b expected 1", stall_o); end
    @(negedge clk);
    pc_i = 32'h3C;
    @(negedge clk);
    pc_i = 32'h50;
    @(negedge clk);
    #1;
    compared++;
    if (stall_o !== 1'b0 || instr_o !== memFn(32'h50)) begin
      mismatched++;
      $display("FAIL wobble_done: got stall %b instr %h expected stall 0 instr %h", stall_o, instr_o, memFn(32'h50));
    end
    for (int w = 1; w < 4; w++) begin
      runFetch(32'h50 + 32'(w * 4), n, got);
      compared++;
      if (n != 0 || got !== memFn(32'h50 + 32'(w * 4))) begin
        mismatched++;
        $display("FAIL wobble_line_word%0d: got stall %0d instr %h expected stall 0 instr %h", w, n, got, memFn(32'h50 + 32'(w * 4)));
      end
    end
    runFetch(32'h18, n, got);
    compared++;
    if (n != 0 || got !== 32'hA2) begin mismatched++; $display("FAIL wobble_line1_intact: got stall %0d instr %h expected stall 0 instr a2", n, got); end
    runFetch(32'h3C, n, got);
    compared++;
    if (n != 0 || got !== memFn(32'h3C)) begin mismatched++; $display("FAIL wobble_line3_intact: got stall %0d instr %h expected stall 0 instr %h", n, got, memFn(32'h3C)); end
    pushLine(32'h130);
    runFetch(32'h134, n, got);
    compared++;
    if (n != 5 || got !== memFn(32'h134)) begin mismatched++; $display("FAIL wobble_other_tag_miss: got stall %0d instr %h expected stall 5 instr %h", n, got, memFn(32'h134)); end
  endtask

  task automatic test_reset_mid_refill();
    int n;
    logic [31:0] got;
    // Two words transfer, the third ack is already on the bus when reset hits.
    addrQ.push_back(32'h40);
    addrQ.push_back(32'h44);
    addrQ.push_back(32'h48);
    @(negedge clk);
    pc_i  = 32'h40;
    req_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (mem_req_o !== 1'b0) begin mismatched++; $display("FAIL midreset_mem_req: got %b expected 0", mem_req_o); end
    compared++;
    if (mem_addr_o !== 32'h0) begin mismatched++; $display("FAIL midreset_mem_addr: got %h expected 0", mem_addr_o); end
    compared++;
    if (stall_o !== 1'b1) begin mismatched++; $display("FAIL midreset_stall: got %b expected 1", stall_o); end
    req_i = 1'b0;
    #1;
    compared++;
    if (stall_o !== 1'b0) begin mismatched++; $display("FAIL midreset_stall_noreq: got %b expected 0", stall_o); end
    @(negedge clk);
    rst = 1'b1;
    pushLine(32'h40);
    runFetch(32'h44, n, got);
    compared++;
    if (n != 5 || got !== memFn(32'h44)) begin mismatched++; $display("FAIL midreset_refetch: got stall %0d instr %h expected stall 5 instr %h", n, got, memFn(32'h44)); end
    pushLine(32'h10);
    runFetch(32'h10, n, got);
    compared++;
    if (n != 5) begin mismatched++; $display("FAIL midreset_valid_cleared: got %0d expected 5", n); end
  endtask

  initial begin
    rst     = 1'b1;
    pc_i    = '0;
    req_i   = 1'b0;
    flush_i = 1'b0;
    test_reset();
    test_cold_miss();
    test_wait_states();
    test_conflict();
    test_flush();
    test_pc_wobble();
    test_reset_mid_refill();
    @(negedge clk);
    req_i = 1'b0;
    compared++;
    if (addrQ.size() != 0) begin
      mismatched++;
      $display("FAIL refill_queue_drained: got %0d pending expected 0", addrQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
